mem_access_ctrl: RTL and testbench

Data-memory access controller for the MEM stage of the pipelined RISC-V core. It takes the load/store request from the EX/MEM register, runs a req/ack handshake with the data-memory bus, and stalls the pipeline until the access completes. It then delivers byte-lane-masked read data, with a one-cycle valid, to the input side of the MEM/WB register. Misaligned and conflicting requests, and bus timeouts, are reported as errors.

---
 rtl/mem_access_ctrl_pkg.sv | 25 ++
 rtl/mem_access_ctrl_if.sv | 22 ++
 rtl/mem_access_ctrl_timeout_ctr.sv | 28 ++
 rtl/mem_access_ctrl.sv | 111 +++++++++++
 tb/tb_mem_access_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package mem_access_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0]  BE_DWORD         = 8'hFF;
    localparam logic [7:0]  BE_NONE          = 8'h00;
    localparam logic [63:0] DWORD_ALIGN_MASK = ~64'h7;

    // A request that must not reach the bus: conflicting, misaligned doubleword or empty lanes.
    function automatic logic isBadRequest(input logic rd, input logic wr,
                                          input logic [2:0] offset, input logic [7:0] be);
        return (rd && wr) || ((be == BE_DWORD) && (offset != 3'b000)) || (be == BE_NONE);
    endfunction

    function automatic logic [63:0] laneMask(input logic [7:0] be);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus: the controller is the master, the memory is the slave.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [63:0]       bus_wdata;
    logic [7:0]        bus_be;
    logic              bus_ack;
    logic [63:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_ctrl_timeout_ctr.sv
// Saturating bus-wait counter; expired marks the last cycle allowed before giving up.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT > 0) && (r_count == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: bus req/ack handshake, pipeline stall and masked read data.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [63:0]        addr,
    input  logic [63:0]        wdata,
    input  logic [7:0]         wmask,
    output logic               stall,
    output logic [63:0]        rdata,
    output logic               rdata_valid,
    output logic               err,
    mem_access_ctrl_if.master  bus
);
    state_t      r_state;
    state_t      w_nextState;
    logic        r_errPending;
    logic [63:0] r_rdata;
    logic        w_req;
    logic        w_bad;
    logic        w_accept;
    logic        w_expired;
    logic        w_unusedAddr;

    assign w_req        = MemRead | MemWrite;
    assign w_bad        = isBadRequest(MemRead, MemWrite, addr[2:0], wmask);
    assign w_accept     = (r_state == IDLE) && w_req && !w_bad;
    assign w_unusedAddr = ^addr;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept),
        .i_enable  (r_state == REQ),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_req) w_nextState = w_bad ? DONE : REQ;
            REQ:     if (bus.bus_ack || w_expired) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Bus registers stay frozen through REQ; an ack on the timeout cycle is still a success.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= '0;
            r_errPending  <= 1'b0;
            r_rdata       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_errPending <= w_bad;
                        r_rdata      <= '0;
                    end
                    if (w_accept) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= MemWrite;
                        bus.bus_addr  <= addr[ADDR_W-1:0] & DWORD_ALIGN_MASK[ADDR_W-1:0];
                        bus.bus_wdata <= wdata;
                        bus.bus_be    <= wmask;
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (!bus.bus_we) r_rdata <= bus.bus_rdata;
                    end else if (w_expired) begin
                        bus.bus_req  <= 1'b0;
                        r_errPending <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall       = w_accept || (r_state == REQ);
        rdata_valid = (r_state == DONE) && !r_errPending;
        err         = (r_state == DONE) && r_errPending;
        rdata       = '0;
        if ((r_state == DONE) && !r_errPending) rdata = r_rdata & laneMask(bus.bus_be);
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a scoreboard queue checks every completion or error strobe.
module tb_mem_access_ctrl;

    typedef struct {
        logic        isErr;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, sel;
    logic [63:0] addr, wdata;
    logic [7:0]  wmask;
    logic        rd1, wr1, rd2, wr2;
    logic        stall1, rv1, err1, stall2, rv2, err2;
    logic [63:0] rdata1, rdata2;
    int          ackDelay = 0;
    logic [63:0] busRdata = '0;
    int          reqCycles1 = 0;
    int          reqCycles2 = 0;
    int          nVectors = 0;
    int          nMiscompares = 0;
    exp_t        expQ[$];

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(32)) bus1 ();
    mem_access_ctrl_if #(.ADDR_W(32)) bus2 ();

    // Only the selected controller sees the request; the other stays idle.
    assign rd1 = MemRead & ~sel;
    assign wr1 = MemWrite & ~sel;
    assign rd2 = MemRead & sel;
    assign wr2 = MemWrite & sel;

    mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .MemRead(rd1), .MemWrite(wr1), .addr(addr), .wdata(wdata),
        .wmask(wmask), .stall(stall1), .rdata(rdata1), .rdata_valid(rv1), .err(err1), .bus(bus1)
    );

    mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dutTo (
        .clk(clk), .rst(rst), .MemRead(rd2), .MemWrite(wr2), .addr(addr), .wdata(wdata),
        .wmask(wmask), .stall(stall2), .rdata(rdata2), .rdata_valid(rv2), .err(err2), .bus(bus2)
    );

    logic        mStall, mReq, mWe, evValid, evErr;
    logic [31:0] mAddr;
    logic [63:0] mWdata, evData;
    logic [7:0]  mBe;
    assign mStall  = sel ? stall2 : stall1;
    assign mReq    = sel ? bus2.bus_req : bus1.bus_req;
    assign mWe     = sel ? bus2.bus_we : bus1.bus_we;
    assign mAddr   = sel ? bus2.bus_addr : bus1.bus_addr;
    assign mWdata  = sel ? bus2.bus_wdata : bus1.bus_wdata;
    assign mBe     = sel ? bus2.bus_be : bus1.bus_be;
    assign evValid = rv1 | rv2;
    assign evErr   = err1 | err2;
    assign evData  = rdata1 | rdata2;

    // Bus slaves: ack on the ackDelay-th cycle of bus_req (0 never acks).
    always @(negedge clk) begin
        bus1.bus_rdata = busRdata;
        bus2.bus_rdata = busRdata;
        if (bus1.bus_req) begin
            reqCycles1++;
            bus1.bus_ack = (reqCycles1 == ackDelay);
        end else begin
            reqCycles1   = 0;
            bus1.bus_ack = 1'b0;
        end
        if (bus2.bus_req) begin
            reqCycles2++;
            bus2.bus_ack = (reqCycles2 == ackDelay);
        end else begin
            reqCycles2   = 0;
            bus2.bus_ack = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (evValid || evErr)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_event", {62'b0, evErr, evValid}, 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("event_err", {63'b0, evErr}, {63'b0, e.isErr});
                checkOutput("event_valid", {63'b0, evValid}, {63'b0, !e.isErr});
                if (!e.isErr) checkOutput("event_rdata", evData, e.data);
            end
        end
    end

    task automatic applyStimulus(input string name, input logic s, input logic rd, input logic wr,
                                 input logic [63:0] a, input logic [63:0] wd, input logic [7:0] m,
                                 input int delay, input logic [63:0] rdat,
                                 input int expStall, input int expReqs, input logic expErr,
                                 input logic [63:0] expData, input logic [31:0] expAddr,
                                 input logic [7:0] expBe);
        exp_t e;
        int   stalls;
        int   reqs;
        logic done;
        @(negedge clk);
        sel = s; MemRead = rd; MemWrite = wr; addr = a; wdata = wd; wmask = m;
        ackDelay = delay; busRdata = rdat;
        e.isErr = expErr;
        e.data  = expData;
        expQ.push_back(e);
        #1;
        stalls = 0; reqs = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (mStall) stalls++;
            if (mReq) begin
                reqs++;
                if (reqs == 1) begin
                    checkOutput({name, "_bus_addr"}, {32'b0, mAddr}, {32'b0, expAddr});
                    checkOutput({name, "_bus_be"}, {56'b0, mBe}, {56'b0, expBe});
                    checkOutput({name, "_bus_we"}, {63'b0, mWe}, {63'b0, wr});
                    if (wr) checkOutput({name, "_bus_wdata"}, mWdata, wd);
                end
            end
            if (evValid || evErr) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        checkOutput({name, "_completed"}, {63'b0, done}, 64'd1);
        checkOutput({name, "_stall_cycles"}, 64'(stalls), 64'(expStall));
        checkOutput({name, "_req_cycles"}, 64'(reqs), 64'(expReqs));
    endtask

    task automatic checkIdleOutputs(input string name);
        checkOutput({name, "_bus_req"}, {63'b0, bus1.bus_req | bus2.bus_req}, 64'd0);
        checkOutput({name, "_stall"}, {63'b0, stall1 | stall2}, 64'd0);
        checkOutput({name, "_bus_we"}, {63'b0, bus1.bus_we | bus2.bus_we}, 64'd0);
        checkOutput({name, "_bus_addr"}, {32'b0, bus1.bus_addr | bus2.bus_addr}, 64'd0);
        checkOutput({name, "_bus_wdata"}, bus1.bus_wdata | bus2.bus_wdata, 64'd0);
        checkOutput({name, "_bus_be"}, {56'b0, bus1.bus_be | bus2.bus_be}, 64'd0);
        checkOutput({name, "_strobes"}, {62'b0, evErr, evValid}, 64'd0);
        checkOutput({name, "_rdata"}, evData, 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        addr = '0; wdata = '0; wmask = '0;
        repeat (3) @(negedge clk);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b0;

        applyStimulus("dw_load", 0, 1, 0, 64'h100, 64'h0, 8'hFF, 1, 64'hDEADBEEF_CAFEF00D,
                      2, 1, 0, 64'hDEADBEEF_CAFEF00D, 32'h100, 8'hFF);
        applyStimulus("byte_store", 0, 0, 1, 64'h10B, 64'hAB << 24, 8'h08, 5, 64'h5555_5555_5555_5555,
                      6, 5, 0, 64'h0, 32'h108, 8'h08);
        applyStimulus("misaligned", 0, 1, 0, 64'h104, 64'h0, 8'hFF, 1, 64'h0,
                      0, 0, 1, 64'h0, 32'h0, 8'h00);
        applyStimulus("rd_and_wr", 0, 1, 1, 64'h200, 64'h77, 8'h0F, 1, 64'h0,
                      0, 0, 1, 64'h0, 32'h0, 8'h00);
        applyStimulus("zero_mask", 0, 1, 0, 64'h40, 64'h0, 8'h00, 1, 64'h0,
                      0, 0, 1, 64'h0, 32'h0, 8'h00);
        applyStimulus("half_load", 0, 1, 0, 64'h33A, 64'h0, 8'h0C, 2, 64'h01234567_89ABCDEF,
                      3, 2, 0, 64'h00000000_89AB0000, 32'h338, 8'h0C);
        applyStimulus("timeout", 1, 1, 0, 64'h80, 64'h0, 8'hFF, 0, 64'h0,
                      5, 4, 1, 64'h0, 32'h80, 8'hFF);
        applyStimulus("ack_at_timeout", 1, 1, 0, 64'h88, 64'h0, 8'h0F, 4, 64'h11223344_55667788,
                      5, 4, 0, 64'h00000000_55667788, 32'h88, 8'h0F);

        // Abandon a load that never gets acked, then confirm the controller recovers.
        @(negedge clk);
        sel = 1'b0; MemRead = 1'b1; addr = 64'h300; wdata = 64'hFEED; wmask = 8'hFF; ackDelay = 0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("mid_access_bus_req", {63'b0, bus1.bus_req}, 64'd1);
        checkOutput("mid_access_stall", {63'b0, stall1}, 64'd1);
        rst = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        #1;
        checkIdleOutputs("mid_reset");
        rst = 1'b0;

        applyStimulus("post_reset_load", 0, 1, 0, 64'h20, 64'h0, 8'hFF, 3, 64'hA5A5A5A5_5A5A5A5A,
                      4, 3, 0, 64'hA5A5A5A5_5A5A5A5A, 32'h20, 8'hFF);

        repeat (3) @(negedge clk);
        #1;
        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
